// File: rtl/libcpu_pkg.sv
// libcpu: TD4 opcode set, instruction-byte encoder and program loader states.
package libcpu;

    typedef enum logic [3:0] {
        ADD_A_IMM, ADD_B_IMM, MOV_A_IMM, MOV_B_IMM,
        MOV_A_B, MOV_B_A, JMP_IMM, JNC_IMM,
        IN_A, IN_B, OUT_B, OUT_IMM,
        NOP, INVALID
    } OPECODE;

    typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} LOADER_STATE;

    localparam logic [3:0] OP_NOP_NIBBLE     = 4'b1010;
    localparam logic [3:0] OP_INVALID_NIBBLE = 4'b1000;

    // Inverse of the CPU decoder table; the immediate is never masked.
    function automatic logic [7:0] encode_instr(OPECODE op, logic [3:0] imm);
        logic [3:0] n;
        case (op)
            ADD_A_IMM: n = 4'b0000;
            ADD_B_IMM: n = 4'b0101;
            MOV_A_IMM: n = 4'b0011;
            MOV_B_IMM: n = 4'b0111;
            MOV_A_B:   n = 4'b0001;
            MOV_B_A:   n = 4'b0100;
            JMP_IMM:   n = 4'b1111;
            JNC_IMM:   n = 4'b1110;
            IN_A:      n = 4'b0010;
            IN_B:      n = 4'b0110;
            OUT_B:     n = 4'b1001;
            OUT_IMM:   n = 4'b1011;
            NOP:       n = OP_NOP_NIBBLE;
            default:   n = OP_INVALID_NIBBLE;
        endcase
        return {n, imm};
    endfunction

endpackage

// File: rtl/program_loader.sv
// program_loader: streams (opcode, imm) pairs into the 16x8 TD4 program memory,
// pads the tail with PAD_BYTE and holds the CPU while loading.
module program_loader
    import libcpu::*;
#(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] PAD_BYTE = 8'hA0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  OPECODE     in_opecode,
    input  logic [3:0] in_imm,
    input  logic       in_last,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       err,
    output logic [4:0] count
);

    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    LOADER_STATE state, state_nxt;
    logic [3:0]  ptr;
    logic [7:0]  enc;
    logic        xfer, last_written;

    assign xfer         = in_valid && in_ready;
    assign enc          = encode_instr(in_opecode, in_imm);
    assign last_written = mem_we && mem_addr == LAST_ADDR;
    assign in_ready     = state == LOAD;
    assign cpu_hold     = state != IDLE;
    assign done         = state == DONE;

    // A transfer at the last address also passes through FILL, which then
    // writes nothing and only waits for that final write to be presented.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = (xfer && (in_last || ptr == LAST_ADDR)) ? FILL : LOAD;
            FILL:    state_nxt = last_written ? DONE : FILL;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            count     <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= 1'b0;
            if (state == IDLE && start) begin
                ptr   <= '0;
                count <= '0;
                err   <= 1'b0;
            end
            if (xfer) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= enc;
                ptr       <= ptr + 4'd1;
                count     <= count + 5'd1;
                err       <= err | (enc[7:4] == OP_INVALID_NIBBLE);
            end else if (state == FILL && !last_written) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= PAD_BYTE;
                ptr       <= ptr + 4'd1;
            end
        end
    end

endmodule
